// File: rtl/alsu_seg_display.sv
// alsu_seg_display
//   Display stage for the ALSU. Shows the 6-bit result in decimal on a
//   4-digit multiplexed 7-segment display. A blinking 'E' in the leftmost
//   digit flags an invalid op (any LED bit set). The value is snapshotted
//   once per scan frame, converted with an iterative double-dabble and
//   applied at the next frame boundary, so a frame never mixes two values.
// Ports
//   i_clk          system clock, posedge
//   i_rst          synchronous active-high reset
//   i_out_val[5:0] ALSU result, 0..63
//   i_leds_in[15:0] ALSU LED word, error = |i_leds_in
//   o_anode[3:0]   digit enables, active-low, bit0 = rightmost digit
//   o_cathode[6:0] segments {g,f,e,d,c,b,a}, active-low
//   o_frame_start  one-cycle pulse at each scan-frame boundary
//   o_conv_busy    high while the BCD conversion shifts
//
// Converter states
//   state   | meaning
//   S_IDLE  | waiting for a frame boundary
//   S_SHIFT | six double-dabble iterations
//   S_DONE  | result copied to the hold registers
module alsu_seg_display #(
  parameter int    REFRESH_DIV  = 50000,
  parameter int    BLINK_FRAMES = 64,
  parameter string LEAD_ZERO    = "OFF"
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [5:0]  i_out_val,
  input  logic [15:0] i_leds_in,
  output logic [3:0]  o_anode,
  output logic [6:0]  o_cathode,
  output logic        o_frame_start,
  output logic        o_conv_busy
);

  localparam int CW    = $clog2(REFRESH_DIV);
  localparam int FW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam bit LZ_ON = (LEAD_ZERO == "ON");

  // Internal digit symbols: 0..9 are decimal digits.
  localparam logic [3:0] SYM_E     = 4'hE;
  localparam logic [3:0] SYM_BLANK = 4'hF;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic          r_frame_start;
  logic [1:0]    r_state;
  logic [5:0]    r_bin;
  logic [6:0]    r_bcd;
  logic [2:0]    r_bits;
  logic          r_err_s;
  logic [3:0]    r_hold_ones, r_hold_tens;
  logic          r_hold_err;
  logic [3:0]    r_disp_ones, r_disp_tens;
  logic          r_disp_err;
  logic [FW-1:0] r_fcnt;
  logic          r_phase;
  logic [3:0]    r_anode;
  logic [6:0]    r_cathode;

  logic          w_tick;
  logic [3:0]    w_ones_adj;
  logic [3:0]    w_ones_nxt, w_tens_nxt;
  logic          w_err_nxt, w_phase_nxt;
  logic [3:0]    w_sym;

  function automatic logic [6:0] seg7(input logic [3:0] sym);
    case (sym)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      SYM_E:   seg7 = 7'b0000110;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Scan timing.
  assign w_tick = (r_cnt == CW'(REFRESH_DIV - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt         <= '0;
      r_idx         <= 2'd0;
      r_frame_start <= 1'b0;
    end else begin
      r_cnt         <= w_tick ? '0 : r_cnt + CW'(1);
      if (w_tick) r_idx <= r_idx + 2'd1;
      r_frame_start <= w_tick && (r_idx == 2'd3);
    end
  end

  // Tens of a 6-bit value never exceeds 6, so before any shift it is at
  // most 3 and never needs the add-3 step; only the ones nibble is adjusted.
  assign w_ones_adj = (r_bcd[3:0] > 4'd4) ? r_bcd[3:0] + 4'd3 : r_bcd[3:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_bin       <= 6'd0;
      r_bcd       <= 7'd0;
      r_bits      <= 3'd0;
      r_err_s     <= 1'b0;
      r_hold_ones <= 4'd0;
      r_hold_tens <= SYM_BLANK;
      r_hold_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_frame_start) begin
            r_bin   <= i_out_val;
            r_err_s <= |i_leds_in;
            r_bcd   <= 7'd0;
            r_bits  <= 3'd0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_bcd  <= {r_bcd[5:4], w_ones_adj, r_bin[5]};
          r_bin  <= {r_bin[4:0], 1'b0};
          r_bits <= r_bits + 3'd1;
          if (r_bits == 3'd5) r_state <= S_DONE;
        end
        S_DONE: begin
          r_hold_ones <= r_bcd[3:0];
          r_hold_tens <= {1'b0, r_bcd[6:4]};
          r_hold_err  <= r_err_s;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Next-cycle display contents. The output registers are fed from these so
  // the very first digit of a new frame already uses the newly loaded value.
  assign w_ones_nxt  = r_frame_start ? r_hold_ones : r_disp_ones;
  assign w_tens_nxt  = r_frame_start ? r_hold_tens : r_disp_tens;
  assign w_err_nxt   = r_frame_start ? r_hold_err  : r_disp_err;
  assign w_phase_nxt = (r_frame_start && (r_fcnt == FW'(BLINK_FRAMES - 1))) ? ~r_phase : r_phase;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_disp_ones <= 4'd0;
      r_disp_tens <= SYM_BLANK;
      r_disp_err  <= 1'b0;
      r_fcnt      <= '0;
      r_phase     <= 1'b0;
    end else begin
      r_disp_ones <= w_ones_nxt;
      r_disp_tens <= w_tens_nxt;
      r_disp_err  <= w_err_nxt;
      r_phase     <= w_phase_nxt;
      if (r_frame_start)
        r_fcnt <= (r_fcnt == FW'(BLINK_FRAMES - 1)) ? '0 : r_fcnt + FW'(1);
    end
  end

  always_comb begin
    w_sym = SYM_BLANK;
    case (r_idx)
      2'd0: w_sym = w_ones_nxt;
      2'd1: begin
        if (!(w_tens_nxt == 4'd0 && !LZ_ON)) w_sym = w_tens_nxt;
      end
      2'd3: w_sym = w_err_nxt ? SYM_E : SYM_BLANK;
      default: w_sym = SYM_BLANK;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_anode   <= 4'b1111;
      r_cathode <= 7'b1111111;
    end else begin
      r_anode   <= (w_err_nxt && w_phase_nxt) ? 4'b1111 : ~(4'b0001 << r_idx);
      r_cathode <= seg7(w_sym);
    end
  end

  assign o_anode       = r_anode;
  assign o_cathode     = r_cathode;
  assign o_frame_start = r_frame_start;
  assign o_conv_busy   = (r_state == S_SHIFT);

endmodule
